// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - boot-time byte stream to RAM word writer
// Packs bytes little-endian into width_a words and writes them from address 0 upward.
module rom_loader #(
  parameter int widthad_a = 15,
  parameter int width_a   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [widthad_a:0]   length,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [widthad_a-1:0] wr_addr,
  output logic [width_a-1:0]   wr_data,
  output logic                 busy,
  output logic                 done
);

  localparam int BPW = width_a / 8;
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BIW-1:0] LAST_BYTE = BIW'(BPW - 1);
  localparam logic [widthad_a:0] FULL_DEPTH = {1'b1, {widthad_a{1'b0}}};

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                 state, state_d;
  logic [widthad_a:0]     words, words_d;
  logic [widthad_a:0]     wcnt, wcnt_d;
  logic [BIW-1:0]         bidx, bidx_d;
  logic [widthad_a-1:0]   addr, addr_d;
  logic [width_a-1:0]     pack_q, pack_d;
  logic [widthad_a-1:0]   wr_addr_d;
  logic [width_a-1:0]     wr_data_d;
  logic                   hs;

  always_comb begin
    state_d   = state;
    words_d   = words;
    wcnt_d    = wcnt;
    bidx_d    = bidx;
    addr_d    = addr;
    pack_d    = pack_q;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    hs        = in_valid & in_ready;

    // start wins over everything, including a handshake or a pending write
    if (start) begin
      state_d = FILL;
      words_d = (length == '0) ? FULL_DEPTH : length;
      wcnt_d  = '0;
      bidx_d  = '0;
      addr_d  = '0;
      pack_d  = '0;
    end else begin
      case (state)
        FILL: begin
          if (hs) begin
            pack_d[8*bidx +: 8] = in_data;
            if (bidx == LAST_BYTE) begin
              state_d   = WRITE;
              bidx_d    = '0;
              wr_addr_d = addr;
              wr_data_d = pack_d;
            end else begin
              bidx_d = bidx + 1'b1;
            end
          end
        end
        WRITE: begin
          if ((wcnt + 1'b1) == words) begin
            state_d = DONE;
          end else begin
            state_d = FILL;
            wcnt_d  = wcnt + 1'b1;
            addr_d  = addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      words    <= '0;
      wcnt     <= '0;
      bidx     <= '0;
      addr     <= '0;
      pack_q   <= '0;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      words    <= words_d;
      wcnt     <= wcnt_d;
      bidx     <= bidx_d;
      addr     <= addr_d;
      pack_q   <= pack_d;
      in_ready <= (state_d == FILL);
      wr_en    <= (state_d == WRITE);
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
      busy     <= (state_d == FILL) || (state_d == WRITE);
      done     <= (state_d == DONE);
    end
  end

endmodule
